// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package fetch_controller_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  // Source of the next PC value
  typedef enum logic [1:0] {
    PC_HOLD  = 2'd0,
    PC_INC   = 2'd1,
    PC_REDIR = 2'd2,
    PC_PEND  = 2'd3
  } pc_sel_t;

  localparam logic [31:0] INSTR_BYTES          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // Instructions are word aligned; low two address bits are always dropped
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_controller_pc_next_select.sv
// Next-PC mux: hold, sequential, redirect target or pending target.
module pc_next_select
  import fetch_controller_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] redirect_target_i,
  input  logic [31:0] pending_i,
  input  pc_sel_t     sel_i,
  output logic [31:0] pc_next_o
);

  // Targets are forced word aligned so a misaligned redirect still fetches
  always_comb begin
    pc_next_o = pc_i;
    unique case (sel_i)
      PC_HOLD:  pc_next_o = pc_i;
      PC_INC:   pc_next_o = pc_plus4_i;
      PC_REDIR: pc_next_o = align_word(redirect_target_i);
      PC_PEND:  pc_next_o = align_word(pending_i);
      default:  pc_next_o = pc_i;
    endcase
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage PC sequencer: owns the PC, issues imem requests, and
// arbitrates redirect > stall > advance across a multi-cycle memory.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Stall_F,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_Target,
  input  logic        IMem_Ready,
  output logic        IMem_Req,
  output logic [31:0] IMem_Addr,
  output logic [31:0] PC_Out,
  output logic [31:0] PC_Plus4,
  output logic        IF_Valid,
  output logic        Flush_D,
  output logic        Misaligned_Target
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_q, pend_d;
  pc_sel_t      sel;
  logic         req_raw, ifv_raw;
  logic         active;

  // Single incrementer shared by the sequential path and the link output
  assign PC_Plus4 = pc_q + INSTR_BYTES;

  pc_next_select u_sel (
    .pc_i              (pc_q),
    .pc_plus4_i        (PC_Plus4),
    .redirect_target_i (Redirect_Target),
    .pending_i         (pend_q),
    .sel_i             (sel),
    .pc_next_o         (pc_d)
  );

  // Next-state, PC source and raw request/valid decode
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    sel     = PC_HOLD;
    req_raw = 1'b0;
    ifv_raw = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        req_raw = ~Stall_F | Redirect_Valid;
        if (Redirect_Valid) begin
          sel = PC_REDIR;
        end else if (Stall_F) begin
          sel = PC_HOLD;
        end else if (IMem_Ready) begin
          sel     = PC_INC;
          ifv_raw = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Request is in flight; address must stay put until ready
        req_raw = 1'b1;
        if (Redirect_Valid && IMem_Ready) begin
          sel     = PC_REDIR;
          state_d = FETCH;
        end else if (Redirect_Valid) begin
          pend_d  = align_word(Redirect_Target);
          state_d = DRAIN;
        end else if (IMem_Ready && Stall_F) begin
          // Completed but stalled: drop the word and refetch same PC
          state_d = FETCH;
        end else if (IMem_Ready) begin
          sel     = PC_INC;
          ifv_raw = 1'b1;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        req_raw = 1'b1;
        if (Redirect_Valid) pend_d = align_word(Redirect_Target);
        if (IMem_Ready) begin
          sel     = Redirect_Valid ? PC_REDIR : PC_PEND;
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // PC, state and pending-target registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      pend_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  // Outputs are masked while in reset and in BOOT
  assign active            = RST_N && (state_q != BOOT);
  assign IMem_Req          = active && req_raw;
  assign IF_Valid          = active && ifv_raw;
  assign Flush_D           = active && Redirect_Valid;
  assign Misaligned_Target = active && Redirect_Valid && (|Redirect_Target[1:0]);
  assign IMem_Addr         = pc_q;
  assign PC_Out            = pc_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed vector bench for fetch_controller.
module tb_fetch_controller;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        Stall_F;
  logic        Redirect_Valid;
  logic [31:0] Redirect_Target;
  logic        IMem_Ready;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic [31:0] PC_Out;
  logic [31:0] PC_Plus4;
  logic        IF_Valid;
  logic        Flush_D;
  logic        Misaligned_Target;

  int checks   = 0;
  int failures = 0;

  fetch_controller #(.RESET_VECTOR(32'h0000_0000)) dut (
    .CLK               (CLK),
    .RST_N             (RST_N),
    .Stall_F           (Stall_F),
    .Redirect_Valid    (Redirect_Valid),
    .Redirect_Target   (Redirect_Target),
    .IMem_Ready        (IMem_Ready),
    .IMem_Req          (IMem_Req),
    .IMem_Addr         (IMem_Addr),
    .PC_Out            (PC_Out),
    .PC_Plus4          (PC_Plus4),
    .IF_Valid          (IF_Valid),
    .Flush_D           (Flush_D),
    .Misaligned_Target (Misaligned_Target)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        rv;
    logic [31:0] tgt;
    logic        rdy;
    logic [31:0] pc;
    logic        req;
    logic        ifv;
    logic        fl;
    logic        mis;
  } vec_t;

  localparam int NV = 34;
  vec_t v [NV];

  function automatic vec_t mk(input logic rst_n, stall, rv, input logic [31:0] tgt,
                              input logic rdy, input logic [31:0] pc,
                              input logic req, ifv, fl, mis);
    vec_t r;
    r.rst_n = rst_n; r.stall = stall; r.rv = rv; r.tgt = tgt; r.rdy = rdy;
    r.pc = pc; r.req = req; r.ifv = ifv; r.fl = fl; r.mis = mis;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst_n, stall, rv, input logic [31:0] tgt, input logic rdy);
    RST_N = rst_n; Stall_F = stall; Redirect_Valid = rv;
    Redirect_Target = tgt; IMem_Ready = rdy;
  endtask

  initial begin
    //          rst st rv tgt           rdy  pc            req ifv fl mis
    v[0]  = mk(0, 0, 1, 32'h3,        0, 32'h0,        0, 0, 0, 0); // in reset, masked
    v[1]  = mk(1, 0, 1, 32'h203,      1, 32'h0,        0, 0, 0, 0); // BOOT ignores redirect
    v[2]  = mk(1, 0, 0, 32'h0,        1, 32'h0,        1, 1, 0, 0);
    v[3]  = mk(1, 0, 0, 32'h0,        1, 32'h4,        1, 1, 0, 0);
    v[4]  = mk(1, 1, 0, 32'h0,        1, 32'h8,        0, 0, 0, 0); // stall x3
    v[5]  = mk(1, 1, 0, 32'h0,        1, 32'h8,        0, 0, 0, 0);
    v[6]  = mk(1, 1, 0, 32'h0,        1, 32'h8,        0, 0, 0, 0);
    v[7]  = mk(1, 0, 0, 32'h0,        1, 32'h8,        1, 1, 0, 0);
    v[8]  = mk(1, 1, 1, 32'h100,      1, 32'hC,        1, 0, 1, 0); // redirect beats stall
    v[9]  = mk(1, 0, 0, 32'h0,        0, 32'h100,      1, 0, 0, 0); // -> WAIT
    v[10] = mk(1, 0, 0, 32'h0,        0, 32'h100,      1, 0, 0, 0);
    v[11] = mk(1, 0, 1, 32'h40,       0, 32'h100,      1, 0, 1, 0); // -> DRAIN
    v[12] = mk(1, 0, 0, 32'h0,        0, 32'h100,      1, 0, 0, 0);
    v[13] = mk(1, 0, 0, 32'h0,        1, 32'h100,      1, 0, 0, 0); // drain done
    v[14] = mk(1, 0, 0, 32'h0,        1, 32'h40,       1, 1, 0, 0);
    v[15] = mk(1, 0, 1, 32'h103,      0, 32'h44,       1, 0, 1, 1); // misaligned
    v[16] = mk(1, 0, 0, 32'h0,        0, 32'h100,      1, 0, 0, 0); // -> WAIT
    v[17] = mk(1, 1, 0, 32'h0,        1, 32'h100,      1, 0, 0, 0); // ready+stall: drop
    v[18] = mk(1, 0, 0, 32'h0,        0, 32'h100,      1, 0, 0, 0); // -> WAIT
    v[19] = mk(1, 0, 0, 32'h0,        1, 32'h100,      1, 1, 0, 0);
    v[20] = mk(1, 0, 0, 32'h0,        0, 32'h104,      1, 0, 0, 0); // -> WAIT
    v[21] = mk(1, 0, 1, 32'hFFFF_FFFC,1, 32'h104,      1, 0, 1, 0); // redirect+ready
    v[22] = mk(1, 0, 0, 32'h0,        1, 32'hFFFF_FFFC,1, 1, 0, 0); // wraps
    v[23] = mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 0); // -> WAIT
    v[24] = mk(1, 0, 1, 32'h80,       0, 32'h0,        1, 0, 1, 0); // -> DRAIN
    v[25] = mk(1, 0, 1, 32'h90,       0, 32'h0,        1, 0, 1, 0); // overwrite pending
    v[26] = mk(1, 0, 0, 32'h0,        1, 32'h0,        1, 0, 0, 0);
    v[27] = mk(1, 0, 0, 32'h0,        0, 32'h90,       1, 0, 0, 0); // -> WAIT
    v[28] = mk(1, 0, 1, 32'hA0,       0, 32'h90,       1, 0, 1, 0); // -> DRAIN
    v[29] = mk(1, 0, 1, 32'hB1,       1, 32'h90,       1, 0, 1, 1); // new target wins
    v[30] = mk(1, 0, 0, 32'h0,        0, 32'hB0,       1, 0, 0, 0); // -> WAIT
    v[31] = mk(0, 0, 0, 32'h0,        0, 32'hB0,       0, 0, 0, 0); // reset mid-WAIT
    v[32] = mk(1, 0, 0, 32'h0,        1, 32'h0,        0, 0, 0, 0); // BOOT
    v[33] = mk(1, 0, 0, 32'h0,        1, 32'h0,        1, 1, 0, 0);

    drive(0, 0, 0, 32'h0, 0);
    @(negedge CLK);
    @(negedge CLK);

    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge CLK);
      drive(v[i].rst_n, v[i].stall, v[i].rv, v[i].tgt, v[i].rdy);
      #1;
      chk($sformatf("v%0d.pc", i),    PC_Out,            v[i].pc);
      chk($sformatf("v%0d.addr", i),  IMem_Addr,         v[i].pc);
      chk($sformatf("v%0d.plus4", i), PC_Plus4,          v[i].pc + 32'd4);
      chk($sformatf("v%0d.req", i),   {31'b0, IMem_Req}, {31'b0, v[i].req});
      chk($sformatf("v%0d.ifv", i),   {31'b0, IF_Valid}, {31'b0, v[i].ifv});
      chk($sformatf("v%0d.flush", i), {31'b0, Flush_D},  {31'b0, v[i].fl});
      chk($sformatf("v%0d.mis", i),   {31'b0, Misaligned_Target}, {31'b0, v[i].mis});
    end

    // Sustained one fetch per cycle with ready tied high
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      drive(1, 0, 0, 32'h0, 1);
      #1;
      chk($sformatf("seq.pc%0d", k), PC_Out, 32'h4 + 32'(4 * k));
      chk($sformatf("seq.ifv%0d", k), {31'b0, IF_Valid}, 32'h1);
    end

    // Reset during DRAIN drops the pending redirect
    @(negedge CLK); drive(1, 0, 0, 32'h0, 0); #1;
    chk("drn.fetch_req", {31'b0, IMem_Req}, 32'h1);
    chk("drn.fetch_pc", PC_Out, 32'h1C);
    @(negedge CLK); drive(1, 0, 1, 32'h200, 0); #1;
    chk("drn.flush", {31'b0, Flush_D}, 32'h1);
    @(negedge CLK); drive(0, 0, 0, 32'h0, 0); #1;
    chk("drn.rst_req", {31'b0, IMem_Req}, 32'h0);
    chk("drn.rst_pc_held", PC_Out, 32'h1C);
    @(negedge CLK); drive(1, 0, 0, 32'h0, 1); #1;
    chk("drn.boot_pc", PC_Out, 32'h0);
    chk("drn.boot_req", {31'b0, IMem_Req}, 32'h0);
    @(negedge CLK); drive(1, 0, 0, 32'h0, 1); #1;
    chk("drn.first_req", {31'b0, IMem_Req}, 32'h1);
    chk("drn.first_pc", PC_Out, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
